// File: rtl/tmr_unit.sv
// Programmable prescaled up-counter timer for the MIPS core's memory-mapped timer.
// Produces the live count, a one-cycle overflow pulse, a sticky flag and a one-shot done status.
module tmr_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      tmr_ctrl,
  output logic [CNT_W-1:0] tmr_cntr,
  output logic             tmr_overflow,
  output logic             tmr_flag,
  output logic             tmr_done
);

  typedef enum logic [1:0] {
    ST_RESTART,
    ST_IDLE,
    ST_HALTED,
    ST_RUN
  } state_t;

  logic [14:0]      r_presc;
  logic [CNT_W-1:0] r_cntr;
  logic             r_en_d;
  logic             r_clr_d;
  logic             r_done;
  logic             r_flag;
  logic             r_ovf;

  logic             w_en;
  logic             w_mode;
  logic             w_clr;
  logic [3:0]       w_p;
  logic [CNT_W-1:0] w_top;
  logic [14:0]      w_presc_lim;
  logic             w_tick;
  logic             w_term;
  state_t           w_state;

  logic [14:0]      w_presc_nxt;
  logic [CNT_W-1:0] w_cntr_nxt;
  logic             w_done_nxt;
  logic             w_flag_nxt;
  logic             w_ovf_nxt;
  logic             w_event;
  logic             w_unused_ctrl;

  assign w_en          = tmr_ctrl[0];
  assign w_mode        = tmr_ctrl[1];
  assign w_clr         = tmr_ctrl[2];
  assign w_p           = tmr_ctrl[7:4];
  assign w_top         = tmr_ctrl[16 +: CNT_W];
  assign w_unused_ctrl = ^{tmr_ctrl[15:8], tmr_ctrl[3]};

  // 2^P - 1 as a right-shifted all-ones mask, so P=15 needs no 16th bit
  assign w_presc_lim = 15'h7FFF >> (4'd15 - w_p);
  assign w_tick      = (r_presc >= w_presc_lim);
  assign w_term      = (r_cntr >= w_top);

  always_comb begin
    if (w_en && !r_en_d) begin
      w_state = ST_RESTART;
    end else if (!w_en) begin
      w_state = ST_IDLE;
    end else if (r_done) begin
      w_state = ST_HALTED;
    end else begin
      w_state = ST_RUN;
    end
  end

  always_comb begin
    w_presc_nxt = r_presc;
    w_cntr_nxt  = r_cntr;
    w_done_nxt  = r_done;
    w_ovf_nxt   = 1'b0;
    w_event     = 1'b0;

    case (w_state)
      ST_RESTART: begin
        w_presc_nxt = '0;
        w_cntr_nxt  = '0;
        w_done_nxt  = 1'b0;
      end
      ST_RUN: begin
        if (!w_tick) begin
          w_presc_nxt = r_presc + 15'd1;
        end else if (!w_term) begin
          w_presc_nxt = '0;
          w_cntr_nxt  = r_cntr + CNT_W'(1);
        end else begin
          w_presc_nxt = '0;
          w_ovf_nxt   = 1'b1;
          w_event     = 1'b1;
          if (w_mode) begin
            w_done_nxt = 1'b1;
          end else begin
            w_cntr_nxt = '0;
          end
        end
      end
      default: begin
      end
    endcase

    // A terminal event on the same edge as a clear wins, so no event is lost
    w_flag_nxt = r_flag;
    if (w_clr && !r_clr_d) begin
      w_flag_nxt = 1'b0;
    end
    if (w_event) begin
      w_flag_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_cntr  <= '0;
      r_en_d  <= 1'b0;
      r_clr_d <= 1'b0;
      r_done  <= 1'b0;
      r_flag  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_presc <= w_presc_nxt;
      r_cntr  <= w_cntr_nxt;
      r_en_d  <= w_en;
      r_clr_d <= w_clr;
      r_done  <= w_done_nxt;
      r_flag  <= w_flag_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign tmr_cntr     = r_cntr;
  assign tmr_overflow = r_ovf;
  assign tmr_flag     = r_flag;
  assign tmr_done     = r_done;

endmodule

// File: tb/tb_tmr_unit.sv
// Self-checking bench for tmr_unit: a table of per-clock vectors plus hand-written
// sequences for TOP lowering, flag-clear collisions and asynchronous reset mid-count.
module tb_tmr_unit;

  logic        clk;
  logic        reset;
  logic [31:0] tmr_ctrl;
  logic [15:0] tmr_cntr;
  logic        tmr_overflow;
  logic        tmr_flag;
  logic        tmr_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] ctrl;
    logic [15:0] cntr;
    logic        ovf;
    logic        flag;
    logic        done;
  } vec_t;

  vec_t vecs[26];

  tmr_unit #(.CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .tmr_ctrl     (tmr_ctrl),
    .tmr_cntr     (tmr_cntr),
    .tmr_overflow (tmr_overflow),
    .tmr_flag     (tmr_flag),
    .tmr_done     (tmr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive the control word, then sample 1 time unit after the next rising edge
  task automatic applyStimulus(input logic [31:0] ctrl);
    tmr_ctrl = ctrl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] cntr,
                             input logic ovf, input logic flag, input logic done);
    checks++;
    if ({tmr_cntr, tmr_overflow, tmr_flag, tmr_done} !== {cntr, ovf, flag, done}) begin
      errors++;
      $display("[TB] FAIL %s: got cntr=%0d ovf=%b flag=%b done=%b, required cntr=%0d ovf=%b flag=%b done=%b",
               name, tmr_cntr, tmr_overflow, tmr_flag, tmr_done, cntr, ovf, flag, done);
    end
  endtask

  task automatic setVec(input int idx, input logic [31:0] ctrl, input logic [15:0] cntr,
                        input logic ovf, input logic flag, input logic done);
    vecs[idx].ctrl = ctrl;
    vecs[idx].cntr = cntr;
    vecs[idx].ovf  = ovf;
    vecs[idx].flag = flag;
    vecs[idx].done = done;
  endtask

  initial begin
    // Periodic P=0 TOP=3: RESTART edge, then 1,2,3, overflow at edge 5 and edge 9
    setVec(0,  32'h0003_0001, 16'd0, 1'b0, 1'b0, 1'b0);
    setVec(1,  32'h0003_0001, 16'd1, 1'b0, 1'b0, 1'b0);
    setVec(2,  32'h0003_0001, 16'd2, 1'b0, 1'b0, 1'b0);
    setVec(3,  32'h0003_0001, 16'd3, 1'b0, 1'b0, 1'b0);
    setVec(4,  32'h0003_0001, 16'd0, 1'b1, 1'b1, 1'b0);
    setVec(5,  32'h0003_0001, 16'd1, 1'b0, 1'b1, 1'b0);
    setVec(6,  32'h0003_0001, 16'd2, 1'b0, 1'b1, 1'b0);
    setVec(7,  32'h0003_0001, 16'd3, 1'b0, 1'b1, 1'b0);
    setVec(8,  32'h0003_0001, 16'd0, 1'b1, 1'b1, 1'b0);
    // Idle keeps the flag; a CLR rising edge while idle clears it
    setVec(9,  32'h0000_0000, 16'd0, 1'b0, 1'b1, 1'b0);
    setVec(10, 32'h0000_0004, 16'd0, 1'b0, 1'b0, 1'b0);
    // One-shot P=2 TOP=1 with CLR held high: RESTART, tick every 4 clocks, terminal 8 edges later
    setVec(11, 32'h0001_0027, 16'd0, 1'b0, 1'b0, 1'b0);
    setVec(12, 32'h0001_0027, 16'd0, 1'b0, 1'b0, 1'b0);
    setVec(13, 32'h0001_0027, 16'd0, 1'b0, 1'b0, 1'b0);
    setVec(14, 32'h0001_0027, 16'd0, 1'b0, 1'b0, 1'b0);
    setVec(15, 32'h0001_0027, 16'd1, 1'b0, 1'b0, 1'b0);
    setVec(16, 32'h0001_0027, 16'd1, 1'b0, 1'b0, 1'b0);
    setVec(17, 32'h0001_0027, 16'd1, 1'b0, 1'b0, 1'b0);
    setVec(18, 32'h0001_0027, 16'd1, 1'b0, 1'b0, 1'b0);
    setVec(19, 32'h0001_0027, 16'd1, 1'b1, 1'b1, 1'b1);
    setVec(20, 32'h0001_0027, 16'd1, 1'b0, 1'b1, 1'b1);
    setVec(21, 32'h0001_0027, 16'd1, 1'b0, 1'b1, 1'b1);
    // MODE back to periodic while halted must not clear done; only RESTART does
    setVec(22, 32'h0001_0025, 16'd1, 1'b0, 1'b1, 1'b1);
    setVec(23, 32'h0001_0024, 16'd1, 1'b0, 1'b1, 1'b1);
    setVec(24, 32'h0001_0023, 16'd0, 1'b0, 1'b1, 1'b0);
    setVec(25, 32'h0001_0023, 16'd0, 1'b0, 1'b1, 1'b0);

    // Reset held with every control bit set: outputs stay zero across clock edges
    reset    = 1'b0;
    tmr_ctrl = 32'hFFFF_FFFF;
    #2;
    checkOutput("reset_async", 16'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset_held", 16'd0, 1'b0, 1'b0, 1'b0);
    tmr_ctrl = 32'h0003_0001;
    reset    = 1'b1;

    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i].ctrl);
      checkOutput($sformatf("vec%0d", i), vecs[i].cntr, vecs[i].ovf, vecs[i].flag, vecs[i].done);
    end

    // TOP lowered below the running count terminates on the next tick, then period 3
    applyStimulus(32'h0000_0000);
    checkOutput("top_idle", 16'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h000A_0001);
    checkOutput("top_restart", 16'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(32'h000A_0001);
      checkOutput($sformatf("top_count%0d", i), 16'(i), 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(32'h0002_0001);
    checkOutput("top_lowered_ovf", 16'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h0002_0001);
    checkOutput("top_p3_c1", 16'd1, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h0002_0001);
    checkOutput("top_p3_c2", 16'd2, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h0002_0001);
    checkOutput("top_p3_ovf", 16'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h0002_0001);
    checkOutput("clr_pre1", 16'd1, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h0002_0001);
    checkOutput("clr_pre2", 16'd2, 1'b0, 1'b1, 1'b0);

    // CLR rising edge colliding with a terminal event leaves the flag set
    applyStimulus(32'h0002_0005);
    checkOutput("clr_collision", 16'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h0002_0001);
    checkOutput("clr_low", 16'd1, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h0002_0005);
    checkOutput("clr_clears", 16'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0002_0005);
    checkOutput("clr_held_event", 16'd0, 1'b1, 1'b1, 1'b0);

    // Run up to a count of 7, then pulse reset low between clock edges
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(32'h0014_0001);
    end
    checkOutput("pre_reset_c7", 16'd7, 1'b0, 1'b1, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("reset_midrun", 16'd0, 1'b0, 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    applyStimulus(32'h0014_0001);
    checkOutput("post_reset_restart", 16'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0014_0001);
    checkOutput("post_reset_c1", 16'd1, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmr_unit.md
# tmr_unit

Programmable 16-bit timer controller for the single-cycle MIPS core. It is configured by the memory-mapped `tmr_ctrl` word driven out of the register file. It sequences a prescaler and an up-counter, and it returns the live count (`tmr_cntr`) and the overflow event (`tmr_overflow`) that the register file and datapath already consume. It also provides sticky status for software polling.

## Interface
Parameters:
- `CNT_W`, default 16, counter width. Fixed at 16 to match `tmr_ctrl[31:16]` and the 16-bit `tmr_cntr` bus.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. `reset`=0 clears all state immediately, independent of `clk`.
- `tmr_ctrl`  in  32  configuration word, sampled every clock:
  - `[0]` EN
  - `[1]` MODE: 0 = periodic, 1 = one-shot
  - `[2]` CLR: flag clear, rising-edge sensitive
  - `[3]` reserved
  - `[7:4]` P: prescale exponent
  - `[15:8]` reserved
  - `[31:16]` TOP
- `tmr_cntr`  out  16  current count value.
- `tmr_overflow`  out  1  one-cycle registered pulse per terminal event.
- `tmr_flag`  out  1  sticky overflow flag.
- `tmr_done`  out  1  one-shot completed, timer halted.

## Operation
Internal state:
- `presc`: 15-bit prescaler.
- `cntr`: 16-bit counter.
- `en_d`: registered EN.
- `clr_d`: registered CLR.
- `done`, `flag`, `ovf`.

Decode:
- `tick` = (`presc` >= 2^P − 1). With P=0, every enabled clock is a tick.
- Terminal condition = `cntr` >= TOP. Using >= (not ==) means a TOP lowered below the current count terminates on the next tick, with no 16-bit wrap.

States, evaluated per clock edge in priority order:
1. **RESTART** (EN=1, `en_d`=0):
   - `cntr`←0, `presc`←0, `done`←0, `ovf`←0.
   - `flag` is unchanged.
2. **IDLE** (EN=0):
   - `cntr`, `presc` and `done` hold, so the count stays readable.
   - `ovf`←0.
   - No pause/resume: re-enabling always passes through RESTART.
3. **HALTED** (EN=1, `done`=1):
   - Everything holds; `ovf`←0.
4. **RUN** (EN=1, `en_d`=1, `done`=0):
   - If not `tick`: `presc`←`presc`+1, `ovf`←0.
   - If `tick` and not terminal: `presc`←0, `cntr`←`cntr`+1, `ovf`←0.
   - If `tick` and terminal: `presc`←0, `ovf`←1, `flag`←1.
     - MODE=0: `cntr`←0.
     - MODE=1: `cntr` holds and `done`←1.

Every clock: `en_d`←EN, `clr_d`←CLR.

Flag clear:
- `flag`←0 when CLR=1 and `clr_d`=0.
- A terminal event on the same edge takes precedence, so `flag` stays 1 and no event is lost.

Outputs:
- `tmr_cntr`=`cntr`, `tmr_overflow`=`ovf`, `tmr_flag`=`flag`, `tmr_done`=`done`.
- All outputs are registered, with no combinational path from `tmr_ctrl` to any output.

Arithmetic:
- Unsigned throughout.
- `presc` never exceeds 2^15 − 1 because it is cleared on every tick.
- `cntr`+1 cannot overflow, since terminal is reached at `cntr`=TOP ≤ 0xFFFF.
- TOP=0: every tick is terminal; `cntr` stays 0 and `ovf` pulses once per tick.
- Changing P or MODE mid-run takes effect on the next edge with no restart.
- Changing MODE from 1 to 0 while halted does not clear `done`; only RESTART clears it.

## Timing
- Reset values: `tmr_cntr`=0, `tmr_overflow`=0, `tmr_flag`=0, `tmr_done`=0; internal `presc`, `en_d`, `clr_d` are 0.
  - Applies immediately on `reset`=0, including mid-count.
  - First state change is at the first `clk` edge after `reset` returns to 1.
  - If EN is already 1 at that edge, the edge is a RESTART.
- Restart latency: counting starts at the RESTART edge E0. With P, TOP fixed:
  - `cntr` reaches k at edge E0 + k·2^P.
  - The terminal event lands at edge E0 + (TOP+1)·2^P.
  - `tmr_overflow` is high for exactly the one cycle after that edge.
- Periodic period: (TOP+1)·2^P clocks between `tmr_overflow` pulses.
- `tmr_done` and `tmr_flag` rise in the same cycle as the `tmr_overflow` pulse.
- CLR takes effect one edge after being sampled high, with no further delay.

## Test plan
- **Reset:** hold `reset`=0 with `tmr_ctrl`=0xFFFF_FFFF → all outputs 0. Release reset → RESTART on the first edge, then `cntr`=1 on the next edge.
- **Periodic, P=0:** `tmr_ctrl`=0x0003_0001 → `cntr` sequence 0,1,2,3,0,1… and `tmr_overflow` pulses every 4 clocks; `tmr_flag`=1 after the first pulse.
- **One-shot, P=2:** `tmr_ctrl`=0x0001_0023 → one `tmr_overflow` pulse 8 clocks after RESTART; `tmr_done`=1 and `cntr` holds 1 indefinitely. Drop EN for 1 clock and re-raise → `cntr`=0, `tmr_done`=0, counting resumes.
- **TOP lowered:** TOP=10, P=0, running; write TOP=2 when `cntr`=5 → overflow on the next edge, `cntr`=0, then period 3.
- **Flag clear collision:** assert the CLR rising edge on the same edge as a terminal event → `tmr_flag` stays 1. A later CLR 0→1 with no event → `tmr_flag`=0 after one edge; holding CLR high does not clear a subsequent event's flag.
- **Async reset mid-run:** pull `reset`=0 for half a cycle at `cntr`=7 → outputs zero immediately, without waiting for a clock edge.
